streaming_deskewer: RTL and testbench
=====================================

// Module: streaming_deskewer
// PURPOSE
// Output-side counterpart of the input skewer. Takes the diagonally skewed result stream
// leaving the systolic array edge (row i lagging row 0 by i cycles) and realigns it into
// whole N-wide vectors, one per cycle. Regenerates vector-level valid/first/last markers
// and counts emitted vectors for the downstream writeback path.
// PARAMETERS
// N          `ARRAY_SIZE  rows per vector (array edge width), N >= 2
// DATA_WIDTH `DATA_WIDTH  bits per element
// COUNT_W    16           width of emitted-vector counter
// PORTS
// clk           in   1              clock, rising edge
// rst_n         in   1              async active-low reset
// en            in   1              global advance; low freezes every register
// data_in       in   DATA_WIDTH[N]  skewed edge data; element k of row i at cycle t0+k+i
// first_in      in   1              pulse with row 0 element 0 (cycle t0)
// last_in       in   1              pulse with row N-1 final element (cycle t0+L-1+N-1)
// data_out      out  DATA_WIDTH[N]  aligned vector, zero outside valid window
// data_out_flat out  N*DATA_WIDTH   data_out[i] at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
// valid_out     out  1              data_out holds an aligned vector
// first_out     out  1              pulse with vector 0
// last_out      out  1              pulse with vector L-1
// busy          out  1              state != IDLE
// vec_count     out  COUNT_W        vectors emitted since last first_out, saturating
// proto_err     out  1              sticky marker-protocol violation
// BEHAVIOUR
// - Reset: all delay regs, markers, data_out, valid_out, first_out, last_out, busy,
//   vec_count, proto_err = 0; state IDLE. Reset mid-stream discards all in-flight data.
// - en=0: no register changes (delay lines, FSM, counters, proto_err hold);
//   outputs stay at current values. All cycle counts below are en-qualified cycles.
// - Row i passes through N-i register stages (row 0: N, row N-1: 1).
//   Vector k (row i element k, all i) appears on data_out at cycle t0+N+k.
// - first_out = first_in delayed N stages. last_out = last_in delayed 1 stage.
//   Both are outputs of registered chains with no combinational input path.
// - valid_out: 1 from the first_out cycle through the last_out cycle inclusive.
//   data_out = aligned regs when valid_out, else 0.
// - FSM: IDLE --first_in--> FILL; FILL --first_out--> STREAM;
//   STREAM --last_out--> IDLE.
//   L=1 stream: first_out and last_out coincide; valid_out high exactly 1 cycle;
//   FILL goes straight to IDLE.
// - vec_count: cleared to 1 on first_out; +1 per valid_out cycle after that; holds at
//   2^COUNT_W-1; holds its value in IDLE.
// - Back-to-back streams: a first_in in the same cycle that last_out fires is accepted
//   and enters FILL.
// - proto_err, set and held until reset:
//   - first_in while busy, other than the last_out case above: first_in is ignored,
//     no second first_out is generated.
//   - last_in while IDLE: last_in is ignored, no last_out.
//   - last_in while FILL is legal and covers short streams.
// - Output is fully registered. Latency from row 0 input to aligned vector = N cycles.
// TESTING  (N=4, DATA_WIDTH=8)
// 1. L=3 stream, row i element k = 16*i+k, en=1:
//    data_out {00,10,20,30} at t0+4, {01,11,21,31} at t0+5, {02,12,22,32} at t0+6;
//    first_out at t0+4, last_out at t0+6; valid_out=1 exactly 3 cycles; vec_count=3.
// 2. L=1 stream:
//    first_out and last_out in the same cycle (t0+4); valid_out=1 one cycle; busy=0 next.
// 3. Test 1 with en=0 for 2 cycles at t0+2:
//    every output shifts 2 cycles later; data values and vec_count=3 are unchanged.
// 4. Second first_in at t0+2 during a stream: proto_err=1; only one first_out.
//    Separately, a second first_in exactly in the last_out cycle: no error,
//    next vector 0 appears 4 cycles later.
// 5. last_in with no prior first_in: proto_err=1, last_out stays 0, valid_out stays 0.
// 6. rst_n low at t0+5 of test 1: all outputs 0 immediately.
//    After release, no stale vectors or markers appear.

Source files
------------

// File: rtl/streaming_deskewer.sv
// Realigns the diagonally skewed result stream from the systolic array edge into whole
// N-wide vectors, regenerating vector-level valid/first/last markers and a vector count.
module streaming_deskewer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_W    = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [N-1:0][DATA_WIDTH-1:0]       data_in,
  input  logic                               first_in,
  input  logic                               last_in,
  output logic [N-1:0][DATA_WIDTH-1:0]       data_out,
  output logic [N*DATA_WIDTH-1:0]            data_out_flat,
  output logic                               valid_out,
  output logic                               first_out,
  output logic                               last_out,
  output logic                               busy,
  output logic [COUNT_W-1:0]                 vec_count,
  output logic                               proto_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [N-1:0]                   first_q;
  logic                           last_q;
  logic                           valid_q, valid_d;
  logic [N-1:0][DATA_WIDTH-1:0]   data_q, data_d, tail;
  logic [COUNT_W-1:0]             cnt_q, cnt_d;
  logic                           err_q;
  logic                           accept_first, accept_last;

  // A new stream may start in the very cycle the previous one emits last_out.
  assign accept_first = first_in & ((state_q == IDLE) | last_q);
  assign accept_last  = last_in & (state_q != IDLE);

  // Row i needs N-i stages in total; the shared output register supplies the last one.
  for (genvar i = 0; i < N; i++) begin : g_row
    if (i < N-1) begin : g_dly
      logic [N-2-i:0][DATA_WIDTH-1:0] sr_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '0;
        end else if (en) begin
          sr_q[0] <= data_in[i];
          for (int j = 1; j < N-1-i; j++) sr_q[j] <= sr_q[j-1];
        end
      end
      assign tail[i] = sr_q[N-2-i];
    end else begin : g_pass
      assign tail[i] = data_in[i];
    end
  end

  // first_q[N-2] is the first_out of the coming cycle, so the window opens in step with it.
  assign valid_d = first_q[N-2] | (valid_q & ~last_q);
  assign data_d  = valid_d ? tail : '0;

  always_comb begin
    cnt_d = cnt_q;
    if (first_q[N-2])                 cnt_d = COUNT_W'(1);
    else if (valid_d && cnt_q != '1)  cnt_d = cnt_q + COUNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      FILL:    if (first_q[N-1]) state_d = last_q ? IDLE : STREAM;
      STREAM:  if (last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept_first) state_d = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      first_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      first_q <= {first_q[N-2:0], accept_first};
      last_q  <= accept_last;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (first_in & ~accept_first) | (last_in & ~accept_last);
    end
  end

  assign data_out      = data_q;
  assign data_out_flat = data_q;
  assign valid_out     = valid_q;
  assign first_out     = first_q[N-1];
  assign last_out      = last_q;
  assign busy          = (state_q != IDLE);
  assign vec_count     = cnt_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_streaming_deskewer.sv
// Directed bench for streaming_deskewer with N=4, DATA_WIDTH=8.
module tb_streaming_deskewer;
  logic              clk = 1'b0;
  logic              rst_n, en;
  logic [3:0][7:0]   data_in, data_out;
  logic [31:0]       data_out_flat;
  logic              first_in, last_in;
  logic              valid_out, first_out, last_out, busy, proto_err;
  logic [15:0]       vec_count;

  int checks = 0;
  int errors = 0;
  int n_first, n_valid, n_last, first_abs;

  streaming_deskewer #(.N(4), .DATA_WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .first_in(first_in),
    .last_in(last_in), .data_out(data_out), .data_out_flat(data_out_flat),
    .valid_out(valid_out), .first_out(first_out), .last_out(last_out), .busy(busy),
    .vec_count(vec_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    data_in  = '0;
    first_in = 1'b0;
    last_in  = 1'b0;
  endtask

  // Skewed stream: row i element k = base+16*i+k presented at cycle rel = k+i.
  task automatic add_stream(input int rel, input int len, input int base);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = rel - i;
      if (k >= 0 && k < len) data_in[i] = data_in[i] | 8'(base + 16*i + k);
    end
    if (rel == 0) first_in = 1'b1;
    if (rel == len + 2) last_in = 1'b1;
  endtask

  task automatic do_reset();
    en    = 1'b1;
    rst_n = 1'b0;
    clear_in();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] vec(input int k);
    return {8'(48 + k), 8'(32 + k), 8'(16 + k), 8'(k)};
  endfunction

  task automatic run_stream(input string nm, input int len, input int stall_at,
                            input int stall_len, input int dup_at);
    int e, abs;
    e = 0; abs = 0;
    n_first = 0; n_valid = 0; n_last = 0; first_abs = -1;
    while (e < len + 7 && abs < 60) begin
      en = !(stall_len > 0 && abs >= stall_at && abs < stall_at + stall_len);
      clear_in();
      add_stream(e, len, 0);
      if (e == dup_at) first_in = 1'b1;
      tick();
      abs++;
      if (en) e++;
      check($sformatf("%s data c%0d", nm, abs), data_out_flat,
            (e >= 4 && e < 4 + len) ? vec(e - 4) : 32'h0);
      check($sformatf("%s valid c%0d", nm, abs), valid_out, (e >= 4 && e < 4 + len));
      check($sformatf("%s first c%0d", nm, abs), first_out, (e == 4));
      check($sformatf("%s last c%0d", nm, abs), last_out, (e == 3 + len));
      check($sformatf("%s busy c%0d", nm, abs), busy, (e >= 1 && e <= 3 + len));
      check($sformatf("%s cnt c%0d", nm, abs), vec_count,
            (e < 4) ? 0 : (e <= 3 + len) ? e - 3 : len);
      check($sformatf("%s err c%0d", nm, abs), proto_err, (dup_at >= 0 && e > dup_at));
      if (first_out) begin n_first++; first_abs = abs; end
      if (valid_out) n_valid++;
      if (last_out) n_last++;
    end
    en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clear_in();
    #1;
    check("reset valid", valid_out, 0);
    check("reset data", data_out_flat, 0);
    check("reset busy", busy, 0);
    check("reset cnt", vec_count, 0);
    do_reset();

    // Test 1: L=3
    run_stream("t1", 3, -1, 0, -1);
    check("t1 nfirst", n_first, 1);
    check("t1 nvalid", n_valid, 3);
    check("t1 first_abs", first_abs, 4);
    check("t1 cnt_end", vec_count, 3);

    // Test 2: L=1
    do_reset();
    run_stream("t2", 1, -1, 0, -1);
    check("t2 nvalid", n_valid, 1);
    check("t2 nlast", n_last, 1);

    // Test 3: L=3 with two stall cycles at t0+2
    do_reset();
    run_stream("t3", 3, 2, 2, -1);
    check("t3 first_abs", first_abs, 6);
    check("t3 nvalid", n_valid, 3);
    check("t3 cnt_end", vec_count, 3);

    // Test 4a: duplicate first_in mid-stream
    do_reset();
    run_stream("t4a", 3, -1, 0, 2);
    check("t4a nfirst", n_first, 1);
    check("t4a err_end", proto_err, 1);

    // Test 4b: second stream starts in the last_out cycle of the first
    do_reset();
    for (int rel = 0; rel < 15; rel++) begin
      int c;
      clear_in();
      add_stream(rel, 3, 0);
      add_stream(rel - 6, 3, 8);
      tick();
      c = rel + 1;
      check($sformatf("t4b first c%0d", c), first_out, (c == 4 || c == 10));
      check($sformatf("t4b last c%0d", c), last_out, (c == 6 || c == 12));
      check($sformatf("t4b valid c%0d", c), valid_out,
            ((c >= 4 && c <= 6) || (c >= 10 && c <= 12)));
      check($sformatf("t4b err c%0d", c), proto_err, 0);
      if (c == 10) check("t4b vec0", data_out_flat, 32'h38281808);
      if (c == 11) check("t4b vec1", data_out_flat, 32'h39291909);
      if (c == 12) check("t4b vec2", data_out_flat, 32'h3a2a1a0a);
      if (c == 10) check("t4b cnt10", vec_count, 1);
      if (c == 13) check("t4b cnt13", vec_count, 3);
    end

    // Test 5: last_in with no stream open
    do_reset();
    last_in = 1'b1;
    tick();
    clear_in();
    for (int c = 1; c < 7; c++) begin
      check($sformatf("t5 err c%0d", c), proto_err, 1);
      check($sformatf("t5 last c%0d", c), last_out, 0);
      check($sformatf("t5 valid c%0d", c), valid_out, 0);
      tick();
    end

    // Test 6: asynchronous reset in the middle of a stream
    do_reset();
    for (int rel = 0; rel < 5; rel++) begin
      clear_in();
      add_stream(rel, 3, 0);
      tick();
    end
    check("t6 pre data", data_out_flat, 32'h31211101);
    rst_n = 1'b0;
    clear_in();
    #1;
    check("t6 rst data", data_out_flat, 0);
    check("t6 rst valid", valid_out, 0);
    check("t6 rst first", first_out, 0);
    check("t6 rst last", last_out, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst cnt", vec_count, 0);
    check("t6 rst err", proto_err, 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("t6 post valid %0d", c), valid_out, 0);
      check($sformatf("t6 post first %0d", c), first_out, 0);
      check($sformatf("t6 post last %0d", c), last_out, 0);
      check($sformatf("t6 post data %0d", c), data_out_flat, 0);
      check($sformatf("t6 post busy %0d", c), busy, 0);
    end
    check("t6 post err", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
